// File: rtl/mux_scan_sequencer_if.sv
// Handshake and scan bus between a word source, the sequencer and the downstream 8:1 registered mux.
// master = word source / mux side, slave = sequencer.
interface mux_scan_sequencer_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       pause;
    logic [7:0] data;
    logic [2:0] select;
    logic       bit_valid;
    logic       first_bit;
    logic       last_bit;
    logic       busy;

    modport master (
        output in_data, in_valid, pause,
        input  in_ready, data, select, bit_valid, first_bit, last_bit, busy
    );

    modport slave (
        input  in_data, in_valid, pause,
        output in_ready, data, select, bit_valid, first_bit, last_bit, busy
    );
endinterface

// File: rtl/mux_scan_sequencer.sv
// Serializes an 8-bit word by stepping the select of a downstream registered 8:1 mux, one index per cycle.
// bit_valid trails select by one cycle; in_ready is low while scanning, pause stalls the scan without losing bits.
module mux_scan_sequencer #(
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    mux_scan_sequencer_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [2:0] START_SEL = MSB_FIRST ? 3'd7 : 3'd0;

    state_t     state;
    state_t     state_nxt;
    logic [2:0] cnt;
    logic [7:0] data_q;
    logic [2:0] select_q;
    logic       bit_valid_q;
    logic       first_bit_q;
    logic       last_bit_q;
    logic       in_ready;
    logic       busy;
    logic       accept;
    logic       issue;
    logic       issue_last;

    assign accept     = bus.in_valid && in_ready;
    assign issue      = (state == SCAN) && !bus.pause;
    assign issue_last = issue && (cnt == 3'd7);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = SCAN;
            SCAN:    if (issue_last) state_nxt = DRAIN;
            DRAIN:   state_nxt = accept ? SCAN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready = 1'b1;
        busy     = 1'b0;
        case (state)
            SCAN: begin
                in_ready = 1'b0;
                busy     = 1'b1;
            end
            DRAIN:   busy = 1'b1;
            default: ;
        endcase
    end

    // The word stays put through DRAIN so the mux can still sample the last index.
    always_ff @(posedge clk) begin
        if (!rst) begin
            data_q      <= 8'd0;
            select_q    <= 3'd0;
            cnt         <= 3'd0;
            bit_valid_q <= 1'b0;
            first_bit_q <= 1'b0;
            last_bit_q  <= 1'b0;
        end else begin
            bit_valid_q <= issue;
            first_bit_q <= issue && (cnt == 3'd0);
            last_bit_q  <= issue_last;
            if (accept) begin
                data_q   <= bus.in_data;
                cnt      <= 3'd0;
                select_q <= START_SEL;
            end else if (issue && !issue_last) begin
                cnt      <= cnt + 3'd1;
                select_q <= MSB_FIRST ? select_q - 3'd1 : select_q + 3'd1;
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.busy      = busy;
    assign bus.data      = data_q;
    assign bus.select    = select_q;
    assign bus.bit_valid = bit_valid_q;
    assign bus.first_bit = first_bit_q;
    assign bus.last_bit  = last_bit_q;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Directed bench for both scan orders; a scoreboard of expected mux bits is checked on every bit_valid pulse.
module tb_mux_scan_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b0;

    mux_scan_sequencer_if b0();
    mux_scan_sequencer_if b1();

    mux_scan_sequencer #(.MSB_FIRST(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(b0));
    mux_scan_sequencer #(.MSB_FIRST(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(b1));

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int pulses0 = 0;
    int pulses1 = 0;
    logic [2:0] q0[$];
    logic [2:0] q1[$];
    logic mux0 = 1'b0;
    logic mux1 = 1'b0;

    // Downstream registered 8:1 muxes.
    always @(posedge clk) begin
        mux0 <= b0.data[b0.select];
        mux1 <= b1.data[b1.select];
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // seq[i] is the i-th bit expected out of the mux, in scan order.
    task automatic push0(input logic [7:0] seq, input int n);
        for (int i = 0; i < n; i++) q0.push_back({seq[i], i == 0, i == 7});
    endtask

    task automatic push1(input logic [7:0] seq, input int n);
        for (int i = 0; i < n; i++) q1.push_back({seq[i], i == 0, i == 7});
    endtask

    always @(negedge clk) begin
        logic [2:0] e;
        if (b0.bit_valid) begin
            pulses0++;
            if (q0.size() == 0) begin
                total++;
                bad++;
                $display("FAIL dut0 unexpected pulse: got bit %0d with nothing expected", mux0);
            end else begin
                e = q0.pop_front();
                chk("dut0 mux bit", int'(mux0), int'(e[2]));
                chk("dut0 first_bit", int'(b0.first_bit), int'(e[1]));
                chk("dut0 last_bit", int'(b0.last_bit), int'(e[0]));
            end
        end
    end

    always @(negedge clk) begin
        logic [2:0] e;
        if (b1.bit_valid) begin
            pulses1++;
            if (q1.size() == 0) begin
                total++;
                bad++;
                $display("FAIL dut1 unexpected pulse: got bit %0d with nothing expected", mux1);
            end else begin
                e = q1.pop_front();
                chk("dut1 mux bit", int'(mux1), int'(e[2]));
                chk("dut1 first_bit", int'(b1.first_bit), int'(e[1]));
                chk("dut1 last_bit", int'(b1.last_bit), int'(e[0]));
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int which);
        int n;
        n = 0;
        while (((which == 0) ? b0.busy : b1.busy) && n < 40) begin
            tick();
            n++;
        end
        total++;
        if (n >= 40) begin
            bad++;
            $display("FAIL idle timeout dut%0d: got busy after %0d cycles required idle", which, n);
        end
    endtask

    initial begin
        int p;
        // Reset with in_valid/pause asserted: reset must win.
        b0.in_data = 8'hEE; b0.in_valid = 1'b1; b0.pause = 1'b1;
        b1.in_data = 8'h00; b1.in_valid = 1'b0; b1.pause = 1'b0;
        rst = 1'b0;
        tick(); tick();
        chk("reset in_ready", int'(b0.in_ready), 1);
        chk("reset busy", int'(b0.busy), 0);
        chk("reset select", int'(b0.select), 0);
        chk("reset data", int'(b0.data), 0);
        chk("reset bit_valid", int'(b0.bit_valid), 0);
        chk("reset first_bit", int'(b0.first_bit), 0);
        chk("reset last_bit", int'(b0.last_bit), 0);
        chk("reset dut1 select", int'(b1.select), 0);
        chk("reset dut1 busy", int'(b1.busy), 0);
        b0.in_valid = 1'b0; b0.pause = 1'b0;
        rst = 1'b1;
        tick();

        // LSB-first 8'hA5: bits 1,0,1,0,0,1,0,1
        p = pulses0;
        push0(8'hA5, 8);
        b0.in_data = 8'hA5; b0.in_valid = 1'b1;
        tick();
        b0.in_valid = 1'b0;
        chk("A5 data", int'(b0.data), 8'hA5);
        for (int j = 1; j <= 10; j++) begin
            if (j <= 9) chk("A5 select", int'(b0.select), (j <= 8) ? j - 1 : 7);
            chk("A5 bit_valid", int'(b0.bit_valid), (j >= 2 && j <= 9) ? 1 : 0);
            chk("A5 busy", int'(b0.busy), (j <= 9) ? 1 : 0);
            chk("A5 in_ready", int'(b0.in_ready), (j >= 9) ? 1 : 0);
            tick();
        end
        chk("A5 pulses", pulses0 - p, 8);

        // MSB-first 8'h81, pause high during the accepting IDLE cycle
        p = pulses1;
        push1(8'h81, 8);
        b1.in_data = 8'h81; b1.in_valid = 1'b1; b1.pause = 1'b1;
        tick();
        b1.in_valid = 1'b0; b1.pause = 1'b0;
        chk("81 busy", int'(b1.busy), 1);
        for (int j = 1; j <= 8; j++) begin
            chk("81 select", int'(b1.select), 8 - j);
            tick();
        end
        wait_idle(1);
        chk("81 pulses", pulses1 - p, 8);

        // Pause for 3 cycles while select==3, plus pause during DRAIN
        p = pulses0;
        push0(8'hF0, 8);
        b0.in_data = 8'hF0; b0.in_valid = 1'b1;
        tick();
        b0.in_valid = 1'b0;
        for (int j = 1; j <= 12; j++) begin
            if (j >= 4 && j <= 7) chk("F0 select hold", int'(b0.select), 3);
            if (j >= 5 && j <= 7) chk("F0 gap", int'(b0.bit_valid), 0);
            b0.pause = ((j >= 4 && j <= 6) || j == 12) ? 1'b1 : 1'b0;
            tick();
        end
        b0.pause = 1'b0;
        chk("F0 idle after drain", int'(b0.busy), 0);
        chk("F0 pulses", pulses0 - p, 8);

        // Back-to-back 8'h0F then 8'h3C with in_data churning during SCAN
        p = pulses0;
        push0(8'h0F, 8);
        push0(8'h3C, 8);
        b0.in_data = 8'h0F; b0.in_valid = 1'b1;
        tick();
        for (int j = 1; j <= 9; j++) begin
            chk("b2b data hold", int'(b0.data), 8'h0F);
            chk("b2b in_ready", int'(b0.in_ready), (j == 9) ? 1 : 0);
            b0.in_data = (j == 9) ? 8'h3C : 8'h50 + 8'(j);
            tick();
        end
        b0.in_valid = 1'b0;
        chk("b2b second data", int'(b0.data), 8'h3C);
        chk("b2b bubble", int'(b0.bit_valid), 0);
        chk("b2b busy", int'(b0.busy), 1);
        tick();
        chk("b2b resume", int'(b0.bit_valid), 1);
        chk("b2b resume first", int'(b0.first_bit), 1);
        wait_idle(0);
        chk("b2b pulses", pulses0 - p, 16);

        // Reset mid-scan: only bits 0..3 of 8'hC3 (1,1,0,0) come out
        p = pulses0;
        push0(8'hC3, 4);
        b0.in_data = 8'hC3; b0.in_valid = 1'b1;
        tick();
        b0.in_valid = 1'b0;
        for (int j = 1; j <= 4; j++) tick();
        rst = 1'b0;
        tick();
        chk("rst busy", int'(b0.busy), 0);
        chk("rst in_ready", int'(b0.in_ready), 1);
        chk("rst select", int'(b0.select), 0);
        chk("rst bit_valid", int'(b0.bit_valid), 0);
        rst = 1'b1;
        for (int j = 0; j < 12; j++) tick();
        chk("rst pulses", pulses0 - p, 4);

        chk("dut0 queue drained", q0.size(), 0);
        chk("dut1 queue drained", q1.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
